// File: rtl/io_pad_tx_buffer_if.sv
// Core-side byte port plus uio pad pins of the transmit pad buffer.
// The master drives bytes and the receiver ack; the slave (the buffer) drives the pads.
interface io_pad_tx_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    pad_data;
  logic [7:0]    pad_oe;
  logic          pad_req;
  logic          pad_ack;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          timeout_err;

  modport master (
    output in_data, in_valid, pad_ack,
    input  in_ready, pad_data, pad_oe, pad_req, fifo_count, busy, timeout_err
  );

  modport slave (
    input  in_data, in_valid, pad_ack,
    output in_ready, pad_data, pad_oe, pad_req, fifo_count, busy, timeout_err
  );
endinterface

// File: rtl/io_pad_tx_buffer.sv
// Byte FIFO driving uio pads with a four-phase req/ack handshake; pad data/oe 2 cycles after push, req 1 later.
// Backpressure: in_ready drops while the FIFO holds DEPTH bytes; a stalled receiver aborts after TIMEOUT cycles.
module io_pad_tx_buffer #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst,
  io_pad_tx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE
  } state_e;

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  state_e                 state_q, state_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             oe_q, oe_d;
  logic                   req_q, req_d;
  logic                   err_q, err_d;
  logic [15:0]            timer_q, timer_d;
  logic                   push;
  logic                   pop;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign push  = bus.in_valid && (count_q < FULL);

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    oe_d    = oe_q;
    req_d   = req_q;
    err_d   = err_q;
    timer_d = timer_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        oe_d  = 8'h00;
        req_d = 1'b0;
        // A receiver still holding ack from an aborted transfer must let go first.
        if ((count_q != '0) && !ack_s) begin
          pop     = 1'b1;
          oe_d    = 8'hFF;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        req_d   = 1'b1;
        timer_d = '0;
        state_d = S_REQ;
      end

      S_REQ: begin
        timer_d = timer_q + 16'd1;
        if (ack_s) begin
          req_d   = 1'b0;
          timer_d = '0;
          state_d = S_RELEASE;
        end else if (timer_q == TO_LAST) begin
          req_d   = 1'b0;
          oe_d    = 8'h00;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end
      end

      S_RELEASE: begin
        timer_d = timer_q + 16'd1;
        if (!ack_s) begin
          timer_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            oe_d    = 8'h00;
            state_d = S_IDLE;
          end
        end else if (timer_q == TO_LAST) begin
          req_d   = 1'b0;
          oe_d    = 8'h00;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sync_q   <= '0;
      state_q  <= S_IDLE;
      data_q   <= '0;
      oe_q     <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pad_ack};
      state_q <= state_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign bus.in_ready    = (count_q < FULL);
  assign bus.pad_data    = data_q;
  assign bus.pad_oe      = oe_q;
  assign bus.pad_req     = req_q;
  assign bus.fifo_count  = count_q;
  assign bus.busy        = (state_q != S_IDLE) || (count_q != '0);
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_io_pad_tx_buffer.sv
// Directed bench for io_pad_tx_buffer: a delayed ack responder plays the receiver and a
// scoreboard monitor checks every byte the receiver latches against the pushed order.
module tb_io_pad_tx_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_pad_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  io_pad_tx_buffer #(
    .DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  logic ack_drv    = 1'b0;
  logic glitch_drv = 1'b0;
  bit   resp_en    = 1'b1;
  int   resp_dly   = 3;
  int   resp_cnt   = 0;
  int   stab_viol  = 0;
  int   oe_viol    = 0;

  assign bus.pad_ack = ack_drv | glitch_drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Receiver model: follows pad_req after resp_dly falling edges.
  always @(negedge clk) begin
    if (resp_en && (bus.pad_req !== ack_drv)) begin
      resp_cnt++;
      if (resp_cnt >= resp_dly) begin
        ack_drv  = bus.pad_req;
        resp_cnt = 0;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // Monitor: a byte is delivered when req and ack are first seen high together.
  logic       prev_acc  = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] prev_oe   = 8'h00;
  logic [2:0] prev_cnt  = 3'd0;
  always @(posedge clk) begin
    logic [7:0] e;
    #2;
    if (!rst) begin
      if (bus.pad_req && bus.pad_ack && !prev_acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got byte 0x%0h, expected no transfer", bus.pad_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_byte", 32'(bus.pad_data), 32'(e));
          chk("sb_oe", 32'(bus.pad_oe), 32'hFF);
        end
      end
      if (prev_hold && (bus.pad_data !== prev_data)) stab_viol++;
      if ((prev_oe == 8'hFF) && (bus.pad_oe != 8'hFF) && (prev_cnt != 3'd0)) oe_viol++;
    end
    prev_acc  = bus.pad_req && bus.pad_ack;
    prev_hold = bus.pad_req || bus.pad_ack;
    prev_data = bus.pad_data;
    prev_oe   = bus.pad_oe;
    prev_cnt  = bus.fifo_count;
  end

  task automatic push(input logic [7:0] d, input bit keep);
    int n = 0;
    while ((bus.in_ready !== 1'b1) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_wait: in_ready=%b, expected 1 within 200 cycles", bus.in_ready);
    end
    if (keep) exp_q.push_back(d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input string nm);
    int n = 0;
    while ((bus.pad_req !== lvl) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(bus.pad_req), 32'(lvl));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.busy !== 1'b0) && (n < 400)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_data"}, 32'(bus.pad_data), 32'h00);
    chk({pfx, "_oe"}, 32'(bus.pad_oe), 32'h00);
    chk({pfx, "_req"}, 32'(bus.pad_req), 32'd0);
    chk({pfx, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({pfx, "_ready"}, 32'(bus.in_ready), 32'd1);
    chk({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    chk({pfx, "_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pa;
    int   n;
    bit   found;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte into an idle block.
    push(8'hA5, 1'b1);
    chk("t2_count", 32'(bus.fifo_count), 32'd1);
    chk("t2_oe_early", 32'(bus.pad_oe), 32'h00);
    @(posedge clk); #1;
    chk("t2_oe", 32'(bus.pad_oe), 32'hFF);
    chk("t2_data", 32'(bus.pad_data), 32'hA5);
    chk("t2_req_low", 32'(bus.pad_req), 32'd0);
    @(posedge clk); #1;
    chk("t2_req_high", 32'(bus.pad_req), 32'd1);
    wait_idle("t2_idle");
    chk("t2_oe_off", 32'(bus.pad_oe), 32'h00);

    // Burst of six: FIFO fills at DEPTH while the first byte is on the pads.
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        chk("t3_full_count", 32'(bus.fifo_count), 32'd4);
        chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
      end
      push(8'(i), 1'b1);
    end
    wait_idle("t3_idle");

    // Push coincident with a RELEASE pop at fifo_count=2.
    push(8'h10, 1'b1);
    push(8'h11, 1'b1);
    push(8'h12, 1'b1);
    chk("t4_count_pre", 32'(bus.fifo_count), 32'd2);
    pa    = bus.pad_ack;
    n     = 0;
    found = 1'b0;
    while (!found && (n < 100)) begin
      @(posedge clk); #1;
      n++;
      if (pa && !bus.pad_ack) found = 1'b1;
      pa = bus.pad_ack;
    end
    chk("t4_ack_fall_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    bus.in_data  = 8'h13;
    bus.in_valid = 1'b1;
    exp_q.push_back(8'h13);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t4_pushpop_count", 32'(bus.fifo_count), 32'd2);
    chk("t4_pop_data", 32'(bus.pad_data), 32'h11);
    @(posedge clk); #1;
    chk("t4_req_next", 32'(bus.pad_req), 32'd1);
    for (int i = 8'h14; i <= 8'h18; i++) push(8'(i), 1'b1);
    wait_idle("t4_idle");

    // Receiver never acks: abort after 8 REQ cycles, byte dropped.
    resp_en = 1'b0;
    push(8'h77, 1'b0);
    wait_req(1'b1, "t5_req_up");
    n = 0;
    while ((bus.pad_req === 1'b1) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_req_cycles", 32'(n), 32'd8);
    chk("t5_err", 32'(bus.timeout_err), 32'd1);
    chk("t5_oe", 32'(bus.pad_oe), 32'h00);
    resp_en = 1'b1;
    push(8'h88, 1'b1);
    wait_idle("t5_next_idle");
    chk("t5_err_sticky", 32'(bus.timeout_err), 32'd1);

    // One-cycle ack pulse only takes effect after the synchronizer.
    resp_en = 1'b0;
    push(8'h3C, 1'b1);
    wait_req(1'b1, "t6_req_up");
    @(negedge clk);
    glitch_drv = 1'b1;
    @(posedge clk); #1;
    chk("t6_req_held", 32'(bus.pad_req), 32'd1);
    chk("t6_data_held", 32'(bus.pad_data), 32'h3C);
    @(negedge clk);
    glitch_drv = 1'b0;
    wait_req(1'b0, "t6_req_drop");
    chk("t6_data_after", 32'(bus.pad_data), 32'h3C);
    wait_idle("t6_idle");
    resp_en = 1'b1;

    // Reset mid-stream: queued bytes are lost, sticky error cleared.
    push(8'h21, 1'b0);
    push(8'h22, 1'b0);
    push(8'h23, 1'b0);
    wait_req(1'b1, "t1_req_up");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("t1_in_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("t1_after");
    repeat (10) @(posedge clk);
    #1;

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    chk("data_stable", 32'(stab_viol), 32'd0);
    chk("oe_between_bytes", 32'(oe_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
